// File: rtl/lc3_control_fsm_if.sv
// Control/status bundle between the LC-3 sequencer (master) and the datapath it steers (slave).
`timescale 1ns/1ps
interface lc3_control_fsm_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;
    logic [6:0] LD_VEC;
    logic [3:0] GATE_VEC;
    logic [1:0] PCMUX;
    logic       DRMUX;
    logic       SR1MUX;
    logic       SR2MUX;
    logic       ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_OE;
    logic       Mem_WE;
    logic       LD_LED;
    logic [4:0] State_out;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_VEC, GATE_VEC, PCMUX, DRMUX, SR1MUX, SR2MUX,
               ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, LD_LED, State_out
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_VEC, GATE_VEC, PCMUX, DRMUX, SR1MUX, SR2MUX,
               ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, LD_LED, State_out
    );
endinterface

// File: rtl/lc3_control_fsm.sv
// LC-3 instruction sequencer: fetch/decode/execute Moore FSM driving datapath loads, bus gates,
// mux selects and memory strobes. Control word is registered alongside the state.
`timescale 1ns/1ps
module lc3_control_fsm #(
    parameter int MEM_WAIT = 3
) (
    input logic               Clk,
    input logic               Reset,
    lc3_control_fsm_if.master bus
);

    typedef enum logic [4:0] {
        HALTED = 5'd0,
        FETCH1,
        FETCH2,
        FETCH3,
        DECODE,
        EX_ADD,
        EX_AND,
        EX_NOT,
        BR0,
        BR1,
        EX_JMP,
        JSR0,
        JSR1,
        LDR0,
        LDR1,
        LDR2,
        STR0,
        STR1,
        STR2,
        PAUSE1,
        PAUSE2
    } state_t;

    // sr2_from_ir and jsr1 mark states whose selects follow live IR bits rather than the state alone
    typedef struct packed {
        logic [6:0] ld;
        logic [3:0] gate;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2_from_ir;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe;
        logic       mem_we;
        logic       ld_led;
        logic       jsr1;
    } ctrl_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    localparam logic [6:0] LD_PC  = 7'b1000000;
    localparam logic [6:0] LD_REG = 7'b0100000;
    localparam logic [6:0] LD_CC  = 7'b0010000;
    localparam logic [6:0] LD_BEN = 7'b0001000;
    localparam logic [6:0] LD_IR  = 7'b0000100;
    localparam logic [6:0] LD_MDR = 7'b0000010;
    localparam logic [6:0] LD_MAR = 7'b0000001;

    localparam logic [3:0] GATE_MARMUX = 4'b1000;
    localparam logic [3:0] GATE_ALU    = 4'b0100;
    localparam logic [3:0] GATE_MDR    = 4'b0010;
    localparam logic [3:0] GATE_PC     = 4'b0001;

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic       wait_done;
    logic       in_mem_state;
    ctrl_t      ctrl;

    assign wait_done    = (wait_cnt == WAIT_LAST);
    assign in_mem_state = (state == FETCH2) || (state == LDR1) || (state == STR2);

    function automatic ctrl_t ctrl_for(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH1: begin
                c.gate = GATE_PC;
                c.ld   = LD_MAR | LD_PC;
            end
            FETCH2, LDR1: begin
                c.mem_oe = 1'b1;
                c.ld     = LD_MDR;
            end
            FETCH3: begin
                c.gate = GATE_MDR;
                c.ld   = LD_IR;
            end
            DECODE: c.ld = LD_BEN;
            EX_ADD, EX_AND, EX_NOT: begin
                c.gate        = GATE_ALU;
                c.ld          = LD_REG | LD_CC;
                c.sr1mux      = 1'b1;
                c.sr2_from_ir = 1'b1;
                c.aluk        = (s == EX_ADD) ? 2'b00 : (s == EX_AND) ? 2'b01 : 2'b10;
            end
            BR1: begin
                c.addr2mux = 2'b10;
                c.pcmux    = 2'b10;
                c.ld       = LD_PC;
            end
            EX_JMP: begin
                c.sr1mux = 1'b1;
                c.aluk   = 2'b11;
                c.gate   = GATE_ALU;
                c.pcmux  = 2'b01;
                c.ld     = LD_PC;
            end
            JSR0: begin
                c.gate  = GATE_PC;
                c.drmux = 1'b1;
                c.ld    = LD_REG;
            end
            JSR1: begin
                c.pcmux = 2'b10;
                c.ld    = LD_PC;
                c.jsr1  = 1'b1;
            end
            LDR0, STR0: begin
                c.addr1mux = 1'b1;
                c.sr1mux   = 1'b1;
                c.addr2mux = 2'b01;
                c.gate     = GATE_MARMUX;
                c.ld       = LD_MAR;
            end
            LDR2: begin
                c.gate = GATE_MDR;
                c.ld   = LD_REG | LD_CC;
            end
            STR1: begin
                c.aluk = 2'b11;
                c.gate = GATE_ALU;
                c.ld   = LD_MDR;
            end
            STR2:    c.mem_we = 1'b1;
            PAUSE1:  c.ld_led = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state = state;
        unique case (state)
            HALTED:  if (bus.Run) next_state = FETCH1;
            FETCH1:  next_state = FETCH2;
            FETCH2:  if (wait_done) next_state = FETCH3;
            FETCH3:  next_state = DECODE;
            DECODE: begin
                case (bus.Opcode)
                    4'b0001: next_state = EX_ADD;
                    4'b0101: next_state = EX_AND;
                    4'b1001: next_state = EX_NOT;
                    4'b0000: next_state = BR0;
                    4'b1100: next_state = EX_JMP;
                    4'b0100: next_state = JSR0;
                    4'b0110: next_state = LDR0;
                    4'b0111: next_state = STR0;
                    4'b1101: next_state = PAUSE1;
                    default: next_state = FETCH1;
                endcase
            end
            EX_ADD, EX_AND, EX_NOT, BR1, EX_JMP, JSR1, LDR2:
                     next_state = FETCH1;
            BR0:     next_state = bus.BEN ? BR1 : FETCH1;
            JSR0:    next_state = JSR1;
            LDR0:    next_state = LDR1;
            LDR1:    if (wait_done) next_state = LDR2;
            STR0:    next_state = STR1;
            STR1:    next_state = STR2;
            STR2:    if (wait_done) next_state = FETCH1;
            PAUSE1:  if (bus.Continue) next_state = PAUSE2;
            PAUSE2:  if (!bus.Continue) next_state = FETCH1;
            default: next_state = HALTED;
        endcase
    end

    // The wait counter restarts whenever a memory state is entered or left, so each access sees 0..MEM_WAIT-1
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= HALTED;
            wait_cnt <= '0;
            ctrl     <= '0;
        end else begin
            state <= next_state;
            ctrl  <= ctrl_for(next_state);
            if (in_mem_state && (next_state == state))
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= '0;
        end
    end

    assign bus.LD_VEC    = ctrl.ld;
    assign bus.GATE_VEC  = ctrl.gate;
    assign bus.PCMUX     = ctrl.pcmux;
    assign bus.DRMUX     = ctrl.drmux;
    assign bus.SR1MUX    = ctrl.sr1mux;
    assign bus.SR2MUX    = ctrl.sr2_from_ir & bus.IR_5;
    assign bus.ADDR1MUX  = ctrl.addr1mux | (ctrl.jsr1 & ~bus.IR_11);
    assign bus.ADDR2MUX  = ctrl.addr2mux | ((ctrl.jsr1 & bus.IR_11) ? 2'b11 : 2'b00);
    assign bus.ALUK      = ctrl.aluk;
    assign bus.Mem_OE    = ctrl.mem_oe;
    assign bus.Mem_WE    = ctrl.mem_we;
    assign bus.LD_LED    = ctrl.ld_led;
    assign bus.State_out = state;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Self-checking bench for lc3_control_fsm: instruction-level sequence model feeding a per-cycle scoreboard.
`timescale 1ns/1ps
module tb_lc3_control_fsm;

    localparam int MEM_WAIT = 3;

    typedef enum int {
        P_HALTED, P_FETCH1, P_FETCH2, P_FETCH3, P_DECODE, P_ADD, P_AND, P_NOT,
        P_BR0, P_BR1, P_JMP, P_JSR0, P_JSR1, P_LDR0, P_LDR1, P_LDR2,
        P_STR0, P_STR1, P_STR2, P_PAUSE1, P_PAUSE2
    } phase_t;

    typedef struct packed {
        logic [6:0] ld;
        logic [3:0] gate;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe;
        logic       mem_we;
        logic       ld_led;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic       run;
        logic       cont;
        logic [3:0] opcode;
        logic       ir5;
        logic       ir11;
        logic       ben;
        phase_t     ph;
    } cycle_t;

    typedef struct {
        phase_t ph;
        ctl_t   exp;
        logic   ir5;
        int     idx;
    } score_t;

    logic Clk = 1'b0;
    logic Reset;
    lc3_control_fsm_if bus();

    lc3_control_fsm #(.MEM_WAIT(MEM_WAIT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int compared   = 0;
    int mismatched = 0;
    int we_run     = 0;

    cycle_t     plan[$];
    score_t     expq[$];
    logic [3:0] cur_op;
    logic       cur_ir5, cur_ir11, cur_ben;

    // Control word each named state must present, straight from the datapath's state table
    function automatic ctl_t expected_ctl(phase_t p, logic ir5, logic ir11);
        ctl_t c;
        c = '0;
        case (p)
            P_FETCH1:         begin c.gate = 4'b0001; c.ld = 7'b1000001; end
            P_FETCH2, P_LDR1: begin c.mem_oe = 1'b1; c.ld = 7'b0000010; end
            P_FETCH3:         begin c.gate = 4'b0010; c.ld = 7'b0000100; end
            P_DECODE:         c.ld = 7'b0001000;
            P_ADD, P_AND, P_NOT: begin
                c.gate   = 4'b0100;
                c.ld     = 7'b0110000;
                c.sr1mux = 1'b1;
                c.sr2mux = ir5;
                c.aluk   = (p == P_ADD) ? 2'd0 : (p == P_AND) ? 2'd1 : 2'd2;
            end
            P_BR1:  begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld = 7'b1000000; end
            P_JMP:  begin c.sr1mux = 1'b1; c.aluk = 2'b11; c.gate = 4'b0100; c.pcmux = 2'b01; c.ld = 7'b1000000; end
            P_JSR0: begin c.gate = 4'b0001; c.drmux = 1'b1; c.ld = 7'b0100000; end
            P_JSR1: begin
                c.pcmux    = 2'b10;
                c.ld       = 7'b1000000;
                c.addr1mux = ~ir11;
                c.addr2mux = ir11 ? 2'b11 : 2'b00;
            end
            P_LDR0, P_STR0: begin
                c.addr1mux = 1'b1; c.sr1mux = 1'b1; c.addr2mux = 2'b01;
                c.gate = 4'b1000; c.ld = 7'b0000001;
            end
            P_LDR2:   begin c.gate = 4'b0010; c.ld = 7'b0110000; end
            P_STR1:   begin c.aluk = 2'b11; c.gate = 4'b0100; c.ld = 7'b0000010; end
            P_STR2:   c.mem_we = 1'b1;
            P_PAUSE1: c.ld_led = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    task automatic add_cycle(phase_t p, logic rst, logic run, logic cont);
        cycle_t c;
        c.rst = rst; c.run = run; c.cont = cont;
        c.opcode = cur_op; c.ir5 = cur_ir5; c.ir11 = cur_ir11; c.ben = cur_ben;
        c.ph = p;
        plan.push_back(c);
    endtask

    task automatic add_fetch(logic [3:0] op, logic ir5, logic ir11, logic ben);
        cur_op = op; cur_ir5 = ir5; cur_ir11 = ir11; cur_ben = ben;
        add_cycle(P_FETCH1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < MEM_WAIT; i++) add_cycle(P_FETCH2, 1'b0, 1'b0, 1'b0);
        add_cycle(P_FETCH3, 1'b0, 1'b0, 1'b0);
        add_cycle(P_DECODE, 1'b0, 1'b0, 1'b0);
    endtask

    // Whole-instruction trace: fetch, decode, then the execute states the opcode calls for
    task automatic add_instr(logic [3:0] op, logic ir5, logic ir11, logic ben);
        add_fetch(op, ir5, ir11, ben);
        case (op)
            4'b0001: add_cycle(P_ADD, 1'b0, 1'b0, 1'b0);
            4'b0101: add_cycle(P_AND, 1'b0, 1'b0, 1'b0);
            4'b1001: add_cycle(P_NOT, 1'b0, 1'b0, 1'b0);
            4'b1100: add_cycle(P_JMP, 1'b0, 1'b0, 1'b0);
            4'b0000: begin
                add_cycle(P_BR0, 1'b0, 1'b0, 1'b0);
                if (ben) add_cycle(P_BR1, 1'b0, 1'b0, 1'b0);
            end
            4'b0100: begin
                add_cycle(P_JSR0, 1'b0, 1'b0, 1'b0);
                add_cycle(P_JSR1, 1'b0, 1'b0, 1'b0);
            end
            4'b0110: begin
                add_cycle(P_LDR0, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < MEM_WAIT; i++) add_cycle(P_LDR1, 1'b0, 1'b0, 1'b0);
                add_cycle(P_LDR2, 1'b0, 1'b0, 1'b0);
            end
            4'b0111: begin
                add_cycle(P_STR0, 1'b0, 1'b0, 1'b0);
                add_cycle(P_STR1, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < MEM_WAIT; i++) add_cycle(P_STR2, 1'b0, 1'b0, 1'b0);
            end
            default: ;
        endcase
    endtask

    // PAUSE: Continue low for low_cycles, high for high_cycles, then low again
    task automatic add_pause(int low_cycles, int high_cycles);
        add_fetch(4'b1101, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < low_cycles; i++) add_cycle(P_PAUSE1, 1'b0, 1'b0, 1'b0);
        add_cycle(P_PAUSE1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < high_cycles - 1; i++) add_cycle(P_PAUSE2, 1'b0, 1'b0, 1'b1);
        add_cycle(P_PAUSE2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_halted(int n, logic rst, logic run_last);
        for (int i = 0; i < n; i++)
            add_cycle(P_HALTED, rst, (i == n - 1) ? run_last : 1'b0, 1'b0);
    endtask

    task automatic pin(string name, logic [7:0] act, logic [7:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic checkOutput(input score_t s);
        ctl_t act;
        act = {bus.LD_VEC, bus.GATE_VEC, bus.PCMUX, bus.DRMUX, bus.SR1MUX, bus.SR2MUX,
               bus.ADDR1MUX, bus.ADDR2MUX, bus.ALUK, bus.Mem_OE, bus.Mem_WE, bus.LD_LED};
        compared++;
        if (act !== s.exp) begin
            mismatched++;
            $display("[TB] FAIL step %0d %s control word: got %h required %h",
                     s.idx, s.ph.name(), act, s.exp);
        end
        case (s.ph)
            P_ADD: begin
                pin("ADD LD_VEC", 8'(bus.LD_VEC), 8'h30);
                pin("ADD GATE_VEC", 8'(bus.GATE_VEC), 8'h04);
                pin("ADD SR2MUX", 8'(bus.SR2MUX), 8'(s.ir5));
            end
            P_BR1: begin
                pin("BR1 PCMUX", 8'(bus.PCMUX), 8'h02);
                pin("BR1 ADDR2MUX", 8'(bus.ADDR2MUX), 8'h02);
            end
            P_PAUSE1: pin("PAUSE1 LD_LED", 8'(bus.LD_LED), 8'h01);
            P_HALTED: pin("HALTED LD_VEC", 8'(bus.LD_VEC), 8'h00);
            default: ;
        endcase
    endtask

    // Single compare process: scoreboard entry per cycle plus memory-strobe shape checks
    always @(negedge Clk) begin : compare
        score_t s;
        if (expq.size() > 0) begin
            s = expq.pop_front();
            checkOutput(s);
        end
        if (bus.Mem_OE === 1'b1 || bus.Mem_WE === 1'b1)
            pin("OE/WE exclusive", 8'(bus.Mem_OE & bus.Mem_WE), 8'h00);
        if (bus.Mem_WE === 1'b1) begin
            we_run++;
        end else if (we_run > 0) begin
            pin("Mem_WE run length", 8'(we_run), 8'd3);
            we_run = 0;
        end
    end

    task automatic applyStimulus();
        foreach (plan[i]) begin
            @(posedge Clk);
            #1;
            Reset        = plan[i].rst;
            bus.Run      = plan[i].run;
            bus.Continue = plan[i].cont;
            bus.Opcode   = plan[i].opcode;
            bus.IR_5     = plan[i].ir5;
            bus.IR_11    = plan[i].ir11;
            bus.BEN      = plan[i].ben;
            expq.push_back('{ph: plan[i].ph,
                             exp: expected_ctl(plan[i].ph, plan[i].ir5, plan[i].ir11),
                             ir5: plan[i].ir5, idx: i});
        end
        @(negedge Clk);
        #1;
    endtask

    initial begin
        Reset        = 1'b1;
        bus.Run      = 1'b0;
        bus.Continue = 1'b0;
        bus.Opcode   = 4'b0000;
        bus.IR_5     = 1'b0;
        bus.IR_11    = 1'b0;
        bus.BEN      = 1'b0;
        cur_op = 4'b0000; cur_ir5 = 1'b0; cur_ir11 = 1'b0; cur_ben = 1'b0;

        add_halted(2, 1'b1, 1'b0);
        add_halted(10, 1'b0, 1'b0);
        add_halted(1, 1'b0, 1'b1);
        add_instr(4'b0001, 1'b1, 1'b0, 1'b0);
        add_instr(4'b0101, 1'b0, 1'b0, 1'b0);
        add_instr(4'b1001, 1'b1, 1'b0, 1'b0);
        add_instr(4'b0000, 1'b0, 1'b0, 1'b0);
        add_instr(4'b0000, 1'b0, 1'b0, 1'b1);
        add_instr(4'b1100, 1'b0, 1'b0, 1'b0);
        add_instr(4'b0100, 1'b0, 1'b1, 1'b0);
        add_instr(4'b0100, 1'b0, 1'b0, 1'b0);
        add_instr(4'b0111, 1'b0, 1'b0, 1'b0);
        add_instr(4'b0110, 1'b0, 1'b0, 1'b0);
        add_pause(2, 3);
        add_instr(4'b1010, 1'b0, 1'b0, 1'b0);

        // Reset lands on the second LDR1 wait cycle; the sequencer must be HALTED with no LD_REG afterwards
        add_fetch(4'b0110, 1'b0, 1'b0, 1'b0);
        add_cycle(P_LDR0, 1'b0, 1'b0, 1'b0);
        add_cycle(P_LDR1, 1'b0, 1'b0, 1'b0);
        add_cycle(P_LDR1, 1'b1, 1'b0, 1'b0);
        add_halted(4, 1'b0, 1'b1);
        add_instr(4'b0001, 1'b1, 1'b0, 1'b0);
        add_instr(4'b0111, 1'b0, 1'b0, 1'b0);
        add_instr(4'b1111, 1'b0, 1'b0, 1'b0);

        $display("[TB] running %0d planned cycles", plan.size());
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
